// File: rtl/pixel_fb_pkg.sv
// Shared types and grayscale coefficients for the pixel frame writer.
// Weights sum to 256 so a full-scale white pixel maps to full-scale gray after the shift.
package pixel_fb_pkg;
    typedef enum logic {
        FILL = 1'b0,
        DROP = 1'b1
    } fb_state_t;

    localparam int unsigned COEF_R     = 77;
    localparam int unsigned COEF_G     = 150;
    localparam int unsigned COEF_B     = 29;
    localparam int unsigned GRAY_SHIFT = 8;
endpackage

// File: rtl/rgb2gray_pipe.sv
// RGB888 -> 8-bit gray, carrying valid/index/frame_done sideband alongside the data.
// Latency: 2 cycles, fully pipelined; no backpressure (accepts one pixel every cycle).
module rgb2gray_pipe
    import pixel_fb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pix_vld,
    input  logic [3*DATA_WIDTH-1:0] rgb_dat,
    input  logic [ADDR_WIDTH-1:0]   pix_addr,
    input  logic                    pix_fd,
    output logic                    gray_vld,
    output logic [DATA_WIDTH-1:0]   gray_dat,
    output logic [ADDR_WIDTH-1:0]   gray_addr,
    output logic                    gray_fd
);
    localparam int PW = DATA_WIDTH + GRAY_SHIFT;
    localparam int SW = PW + 1;

    logic [PW-1:0]         r_prod, g_prod, b_prod;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic                  s1_vld, s1_fd;
    logic [SW-1:0]         sum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_vld   <= 1'b0;
            s1_fd    <= 1'b0;
            gray_vld <= 1'b0;
            gray_fd  <= 1'b0;
        end else begin
            s1_vld   <= pix_vld;
            s1_fd    <= pix_fd;
            gray_vld <= s1_vld;
            gray_fd  <= s1_fd;
        end
    end

    always_ff @(posedge clk) begin
        r_prod    <= PW'(rgb_dat[3*DATA_WIDTH-1 -: DATA_WIDTH]) * PW'(COEF_R);
        g_prod    <= PW'(rgb_dat[2*DATA_WIDTH-1 -: DATA_WIDTH]) * PW'(COEF_G);
        b_prod    <= PW'(rgb_dat[DATA_WIDTH-1:0]) * PW'(COEF_B);
        s1_addr   <= pix_addr;
        gray_dat  <= DATA_WIDTH'(sum >> GRAY_SHIFT);
        gray_addr <= s1_addr;
    end

    // Max sum is 255*256, so the shifted result always fits without clamping.
    assign sum = SW'(r_prod) + SW'(g_prod) + SW'(b_prod);
endmodule

// File: rtl/pixel_frame_writer.sv
// Grayscale pixel stream into a 2-bank ping-pong frame buffer with a frame valid/release read port.
// Latency: write 2 cycles after pixel_done, read data 1 cycle after rd_addr; no backpressure, full buffers drop whole frames.
module pixel_frame_writer
    import pixel_fb_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int IMG_WIDTH       = 80,
    parameter int IMG_HEIGHT      = 120,
    parameter int TOTAL_PIXELS    = IMG_WIDTH * IMG_HEIGHT,
    parameter int PIXEL_CNT_WIDTH = $clog2(TOTAL_PIXELS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [3*DATA_WIDTH-1:0]    rgb_data,
    input  logic                       pixel_done,
    input  logic [PIXEL_CNT_WIDTH-1:0] pixel_cnt,
    input  logic                       frame_done,
    input  logic [PIXEL_CNT_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       frame_valid,
    input  logic                       frame_release,
    output logic                       wr_bank,
    output logic                       rd_bank,
    output logic                       overflow,
    output logic                       seq_err,
    output logic                       short_frame
);
    localparam int CW        = PIXEL_CNT_WIDTH + 1;
    localparam int MEM_DEPTH = 2 * TOTAL_PIXELS;
    localparam int MEM_AW    = $clog2(MEM_DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(TOTAL_PIXELS);

    fb_state_t                  state, state_n;
    logic [1:0]                 bank_full, full_rel, full_n;
    logic                       wr_bank_n, rd_bank_n;
    logic [CW-1:0]              wr_cnt, wr_cnt_n;
    logic                       mem_we, ovf_set, seq_set, short_set;
    logic                       p_vld, p_fd;
    logic [DATA_WIDTH-1:0]      p_gray;
    logic [PIXEL_CNT_WIDTH-1:0] p_addr;
    logic [MEM_AW-1:0]          wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0]      mem [MEM_DEPTH];

    rgb2gray_pipe #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(PIXEL_CNT_WIDTH)
    ) u_gray (
        .clk      (clk),
        .reset    (reset),
        .pix_vld  (pixel_done),
        .rgb_dat  (rgb_data),
        .pix_addr (pixel_cnt),
        .pix_fd   (frame_done),
        .gray_vld (p_vld),
        .gray_dat (p_gray),
        .gray_addr(p_addr),
        .gray_fd  (p_fd)
    );

    always_comb begin
        full_rel  = bank_full;
        rd_bank_n = rd_bank;
        state_n   = state;
        wr_bank_n = wr_bank;
        wr_cnt_n  = wr_cnt;
        mem_we    = 1'b0;
        ovf_set   = 1'b0;
        seq_set   = 1'b0;
        short_set = 1'b0;
        // Release is resolved first so a same-cycle commit sees the freed bank.
        if (frame_release && bank_full[rd_bank]) begin
            full_rel[rd_bank] = 1'b0;
            rd_bank_n         = ~rd_bank;
        end
        full_n = full_rel;
        if (p_vld) begin
            if (state == DROP) begin
                ovf_set = 1'b1;
            end else if (wr_cnt == FULL_CNT) begin
                seq_set = 1'b1;
            end else begin
                mem_we   = 1'b1;
                wr_cnt_n = wr_cnt + 1'b1;
                if ({1'b0, p_addr} != wr_cnt) seq_set = 1'b1;
            end
        end
        if (p_fd) begin
            if (state == FILL) begin
                if (wr_cnt_n == FULL_CNT) begin
                    full_n[wr_bank] = 1'b1;
                    if (!full_rel[~wr_bank]) wr_bank_n = ~wr_bank;
                    else                     state_n   = DROP;
                end else begin
                    short_set = 1'b1;
                end
                wr_cnt_n = '0;
            end else if (!(&full_rel)) begin
                state_n   = FILL;
                wr_bank_n = full_rel[0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FILL;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            bank_full   <= 2'b00;
            wr_cnt      <= '0;
            overflow    <= 1'b0;
            seq_err     <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            state       <= state_n;
            wr_bank     <= wr_bank_n;
            rd_bank     <= rd_bank_n;
            bank_full   <= full_n;
            wr_cnt      <= wr_cnt_n;
            overflow    <= overflow | ovf_set;
            seq_err     <= seq_err | seq_set;
            short_frame <= short_frame | short_set;
        end
    end

    assign wr_idx = MEM_AW'(wr_cnt) + (wr_bank ? MEM_AW'(TOTAL_PIXELS) : MEM_AW'(0));
    assign rd_idx = MEM_AW'(rd_addr) + (rd_bank ? MEM_AW'(TOTAL_PIXELS) : MEM_AW'(0));

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_idx] <= p_gray;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_data <= '0;
        else        rd_data <= mem[rd_idx];
    end

    assign frame_valid = bank_full[rd_bank];
endmodule

// File: tb/tb_pixel_frame_writer.sv
// Randomized bench for pixel_frame_writer on a 4x2 image, checked every cycle against a frame-level model.
module tb_pixel_frame_writer;
    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [23:0] rgb_data = '0;
    logic        pixel_done = 1'b0;
    logic [2:0]  pixel_cnt = '0;
    logic        frame_done = 1'b0;
    logic [2:0]  rd_addr = '0;
    logic [7:0]  rd_data;
    logic        frame_valid;
    logic        frame_release = 1'b0;
    logic        wr_bank, rd_bank, overflow, seq_err, short_frame;

    int total = 0;
    int bad = 0;

    pixel_frame_writer #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(2)) dut (
        .clk(clk), .reset(reset), .rgb_data(rgb_data), .pixel_done(pixel_done),
        .pixel_cnt(pixel_cnt), .frame_done(frame_done), .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_valid(frame_valid), .frame_release(frame_release), .wr_bank(wr_bank),
        .rd_bank(rd_bank), .overflow(overflow), .seq_err(seq_err), .short_frame(short_frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gray_of(input logic [23:0] p);
        return (77 * p[23:16] + 150 * p[15:8] + 29 * p[7:0]) / 256;
    endfunction

    // Frame-level model: an input event takes effect on the 2nd clock edge after it is sampled.
    typedef struct packed {
        logic       pix;
        logic [2:0] cnt;
        logic [7:0] gray;
        logic       fd;
    } ev_t;

    ev_t  hist [2];
    bit   [1:0] m_full;
    bit   m_wr, m_rd, m_drop, m_ovf, m_seq, m_short, m_rdchk;
    int   m_cnt, m_rdd;
    int   m_mem [2*T];

    task automatic m_clear();
        hist[0] = '0; hist[1] = '0;
        m_full = 2'b00; m_wr = 0; m_rd = 0; m_drop = 0;
        m_ovf = 0; m_seq = 0; m_short = 0; m_cnt = 0;
        m_rdchk = 1; m_rdd = 0;
    endtask

    task automatic m_step();
        ev_t ev;
        m_rdchk = m_full[m_rd];
        if (m_full[m_rd]) m_rdd = m_mem[int'(m_rd) * T + int'(rd_addr)];
        if (frame_release && m_full[m_rd]) begin
            m_full[m_rd] = 1'b0;
            m_rd = !m_rd;
        end
        ev = hist[1];
        if (ev.pix) begin
            if (m_drop) m_ovf = 1;
            else if (m_cnt == T) m_seq = 1;
            else begin
                if (int'(ev.cnt) != m_cnt) m_seq = 1;
                m_mem[int'(m_wr) * T + m_cnt] = int'(ev.gray);
                m_cnt = m_cnt + 1;
            end
        end
        if (ev.fd) begin
            if (!m_drop) begin
                if (m_cnt == T) begin
                    m_full[m_wr] = 1'b1;
                    if (!m_full[!m_wr]) m_wr = !m_wr;
                    else m_drop = 1;
                end else m_short = 1;
                m_cnt = 0;
            end else if (!(m_full[0] && m_full[1])) begin
                m_wr = m_full[0];
                m_drop = 0;
            end
        end
        hist[1] = hist[0];
        hist[0] = '{pix: pixel_done, cnt: pixel_cnt, gray: 8'(gray_of(rgb_data)), fd: frame_done};
    endtask

    initial begin
        m_clear();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) m_clear();
            else m_step();
        end
    end

    always @(negedge clk) begin
        chk("frame_valid", int'(frame_valid), int'(m_full[m_rd]));
        chk("wr_bank", int'(wr_bank), int'(m_wr));
        chk("rd_bank", int'(rd_bank), int'(m_rd));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("seq_err", int'(seq_err), int'(m_seq));
        chk("short_frame", int'(short_frame), int'(m_short));
        if (m_rdchk) chk("rd_data", int'(rd_data), m_rdd);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_pix(input logic [23:0] rgb, input logic [2:0] idx);
        rgb_data = rgb; pixel_cnt = idx; pixel_done = 1'b1;
        rd_addr = 3'($urandom_range(0, 7));
        tick();
        pixel_done = 1'b0;
        idle($urandom_range(0, 2));
    endtask

    task automatic send_fd();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    task automatic send_frame(input int n);
        for (int i = 0; i < n; i++) send_pix(24'($urandom), 3'(i));
        send_fd();
        idle(4);
    endtask

    task automatic release_bank();
        frame_release = 1'b1;
        tick();
        frame_release = 1'b0;
        idle(1);
    endtask

    task automatic read_lit(input logic [2:0] a, input int exp, input string name);
        rd_addr = a;
        @(posedge clk);
        @(negedge clk);
        chk(name, int'(rd_data), exp);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_fv"}, int'(frame_valid), 0);
        chk({tag, "_rd_data"}, int'(rd_data), 0);
        chk({tag, "_wr_bank"}, int'(wr_bank), 0);
        chk({tag, "_rd_bank"}, int'(rd_bank), 0);
        chk({tag, "_overflow"}, int'(overflow), 0);
        chk({tag, "_seq_err"}, int'(seq_err), 0);
        chk({tag, "_short"}, int'(short_frame), 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("rst");
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        @(negedge clk);
        check_reset_vals("por");
        tick();
        reset = 1'b1;
        tick();

        // Single frame with pixel k = {30k,20k,10k}; commit latency and bank flip.
        for (int k = 0; k < T; k++) send_pix({8'(k * 30), 8'(k * 20), 8'(k * 10)}, 3'(k));
        send_fd();
        @(negedge clk); chk("fv_lat1", int'(frame_valid), 0);
        tick(); @(negedge clk); chk("fv_lat2", int'(frame_valid), 0);
        tick(); @(negedge clk); chk("fv_lat3", int'(frame_valid), 1);
        chk("single_wr_bank", int'(wr_bank), 1);
        for (int k = 0; k < T; k++) read_lit(3'(k), int'(m_mem[k]), "single_rd");
        read_lit(3'd7, (77 * 210 + 150 * 140 + 29 * 70) >> 8, "gray_k7");
        read_lit(3'd0, 0, "gray_k0");
        tick();
        release_bank();

        // Extremes land in bank 1.
        send_pix(24'hFFFFFF, 3'd0);
        send_pix(24'h000000, 3'd1);
        send_pix(24'hFF0000, 3'd2);
        send_pix(24'h00FF00, 3'd3);
        for (int k = 4; k < T; k++) send_pix(24'($urandom), 3'(k));
        send_fd();
        idle(4);
        read_lit(3'd0, 255, "gray_white");
        read_lit(3'd1, 0, "gray_black");
        read_lit(3'd2, 76, "gray_red");
        read_lit(3'd3, 149, "gray_green");
        tick();
        release_bank();

        // Ping-pong fill, overflow, release coinciding with the dropped frame's frame_done.
        do_reset();
        send_frame(T);
        send_frame(T);
        chk("pp_ovf_before", int'(overflow), 0);
        chk("pp_wr_bank_drop", int'(wr_bank), 1);
        for (int k = 0; k < T; k++) send_pix(24'($urandom), 3'(k));
        idle(3);
        chk("pp_ovf_after", int'(overflow), 1);
        frame_done = 1'b1; frame_release = 1'b1;
        tick();
        frame_done = 1'b0; frame_release = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk("pp_fv_hold", int'(frame_valid), 1);
            tick();
        end
        chk("pp_wr_bank_free", int'(wr_bank), 0);
        chk("pp_rd_bank", int'(rd_bank), 1);
        send_frame(T);
        release_bank();
        chk("pp_f4_bank0_fv", int'(frame_valid), 1);
        chk("pp_f4_rd_bank", int'(rd_bank), 0);
        for (int k = 0; k < T; k++) read_lit(3'(k), m_mem[k], "pp_f4_rd");
        tick();

        // Commit and release on the same clock edge with both banks in use.
        do_reset();
        send_frame(T);
        for (int k = 0; k < T; k++) send_pix(24'($urandom), 3'(k));
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        tick();
        frame_release = 1'b1;
        tick();
        frame_release = 1'b0;
        idle(3);
        chk("sim_overflow", int'(overflow), 0);
        chk("sim_fv", int'(frame_valid), 1);
        chk("sim_rd_bank", int'(rd_bank), 1);
        chk("sim_wr_bank", int'(wr_bank), 0);
        send_frame(T);

        // Short frame, skipped index, ninth pixel.
        do_reset();
        send_frame(5);
        chk("short_flag", int'(short_frame), 1);
        chk("short_fv", int'(frame_valid), 0);
        chk("short_wr_bank", int'(wr_bank), 0);
        send_frame(T);
        chk("after_short_fv", int'(frame_valid), 1);
        chk("after_short_wr", int'(wr_bank), 1);
        release_bank();
        for (int k = 0; k < T; k++) send_pix(24'($urandom), (k < 4) ? 3'(k) : 3'((k < 7) ? k + 1 : 7));
        send_fd();
        idle(4);
        chk("skip_seq_err", int'(seq_err), 1);
        do_reset();
        for (int k = 0; k < T; k++) send_pix(24'($urandom), 3'(k));
        idle(3);
        chk("nine_seq_before", int'(seq_err), 0);
        send_pix(24'($urandom), 3'd0);
        idle(3);
        chk("nine_seq_after", int'(seq_err), 1);
        send_fd();
        idle(4);
        chk("nine_fv", int'(frame_valid), 1);

        // Reset in the middle of a frame, then a clean frame.
        do_reset();
        send_frame(T);
        for (int k = 0; k < 4; k++) send_pix(24'($urandom), 3'(k));
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("mid");
        tick();
        reset = 1'b1;
        tick();
        send_frame(T);
        chk("mid_fv", int'(frame_valid), 1);
        chk("mid_wr_bank", int'(wr_bank), 1);
        chk("mid_rd_bank", int'(rd_bank), 0);
        for (int k = 0; k < T; k++) read_lit(3'(k), m_mem[k], "mid_rd");
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
